// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline controller: exception codes, stall
// patterns, FSM state encoding and the stall priority encoder.
package pipe_ctrl_pkg;

    localparam logic [31:0] EXC_NONE         = 32'h0000_0000;
    localparam logic [31:0] EXC_INT          = 32'h0000_0001;
    localparam logic [31:0] EXC_SYSCALL      = 32'h0000_0008;
    localparam logic [31:0] EXC_INST_INVALID = 32'h0000_000a;
    localparam logic [31:0] EXC_OV           = 32'h0000_000c;
    localparam logic [31:0] EXC_TRAP         = 32'h0000_000d;
    localparam logic [31:0] EXC_ERET         = 32'h0000_000e;

    localparam logic [31:0] EXC_VECTOR_DEFAULT = 32'h0000_0020;

    // bit0 pc, bit1 if, bit2 id, bit3 ex, bit4 mem, bit5 wb; 1 = hold
    localparam logic [5:0] STALL_NONE = 6'b000000;
    localparam logic [5:0] STALL_IF   = 6'b000011;
    localparam logic [5:0] STALL_ID   = 6'b000111;
    localparam logic [5:0] STALL_EX   = 6'b001111;
    localparam logic [5:0] STALL_MEM  = 6'b011111;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_PEND  = 2'd1,
        ST_FLUSH = 2'd2
    } state_t;

    // The deepest requesting stage wins: it freezes itself and everything
    // upstream of it, while stages downstream keep draining.
    function automatic logic [5:0] stall_encode(input logic req_if,
                                                input logic req_id,
                                                input logic req_ex,
                                                input logic req_mem);
        if (req_mem)     return STALL_MEM;
        else if (req_ex) return STALL_EX;
        else if (req_id) return STALL_ID;
        else if (req_if) return STALL_IF;
        else             return STALL_NONE;
    endfunction

endpackage

// File: rtl/pipe_ctrl_if.sv
// Pipeline <-> controller bundle. master = pipeline stages (raise requests,
// report exceptions), slave = pipe_ctrl (returns stall/flush/redirect).
interface pipe_ctrl_if;
    logic        stallreq_from_if;
    logic        stallreq_from_id;
    logic        stallreq_from_ex;
    logic        stallreq_from_mem;
    logic [31:0] excepttype;
    logic [31:0] cp0_epc;
    logic [5:0]  stall;
    logic        flush;
    logic [31:0] new_pc;

    modport master (
        output stallreq_from_if, stallreq_from_id, stallreq_from_ex,
               stallreq_from_mem, excepttype, cp0_epc,
        input  stall, flush, new_pc
    );

    modport slave (
        input  stallreq_from_if, stallreq_from_id, stallreq_from_ex,
               stallreq_from_mem, excepttype, cp0_epc,
        output stall, flush, new_pc
    );
endinterface

// File: rtl/pipe_ctrl_exc_target.sv
// exc_target: maps an exception code to its redirect address. eret returns
// to EPC; every other nonzero code enters the common exception vector.
module exc_target
    import pipe_ctrl_pkg::*;
#(
    parameter logic [31:0] EXC_VECTOR = EXC_VECTOR_DEFAULT
) (
    input  logic [31:0] excepttype,
    input  logic [31:0] epc,
    output logic [31:0] new_pc
);

    // Redirect target selection; unknown codes fall back to the vector.
    always_comb begin
        new_pc = EXC_VECTOR;
        case (excepttype)
            EXC_ERET:                       new_pc = epc;
            EXC_INT, EXC_SYSCALL,
            EXC_INST_INVALID, EXC_TRAP,
            EXC_OV:                         new_pc = EXC_VECTOR;
            default:                        new_pc = EXC_VECTOR;
        endcase
    end

endmodule

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: merges stage stall requests into the stall vector and
// sequences exception / eret redirection (RUN -> [PEND] -> FLUSH -> RUN).
// An exception seen while mem is stalled is parked in PEND until the
// memory access completes, so the faulting access is not torn down midway.
// Optional build macro PIPE_CTRL_PERF_EN adds stall-cycle and flush counters.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter logic [31:0] EXC_VECTOR = EXC_VECTOR_DEFAULT
) (
    input  logic         clk,
    input  logic         rst,
    pipe_ctrl_if.slave   bus
`ifdef PIPE_CTRL_PERF_EN
    ,
    output logic [31:0]  perf_stall_cycles,
    output logic [31:0]  perf_flush_count
`endif
);

    state_t      state, state_nxt;
    logic [31:0] pend_code, pend_epc;
    logic        latch_en;
    logic        use_pend;
    logic [5:0]  stall_c;
    logic        flush_c;
    logic [31:0] tgt_code, tgt_epc, tgt_pc;

    // State register; reset lands in RUN from any state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_RUN;
        else     state <= state_nxt;
    end

    // Park the exception that arrived during a mem stall; later live inputs
    // are ignored until it has been flushed.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_code <= '0;
            pend_epc  <= '0;
        end else if (latch_en) begin
            pend_code <= bus.excepttype;
            pend_epc  <= bus.cp0_epc;
        end
    end

    // Next-state and Mealy outputs; flush always comes with stall = 0.
    always_comb begin
        state_nxt = state;
        stall_c   = STALL_NONE;
        flush_c   = 1'b0;
        latch_en  = 1'b0;
        use_pend  = 1'b0;
        case (state)
            ST_RUN: begin
                if (bus.excepttype != EXC_NONE) begin
                    if (bus.stallreq_from_mem) begin
                        stall_c   = STALL_MEM;
                        latch_en  = 1'b1;
                        state_nxt = ST_PEND;
                    end else begin
                        flush_c   = 1'b1;
                        state_nxt = ST_FLUSH;
                    end
                end else begin
                    stall_c = stall_encode(bus.stallreq_from_if, bus.stallreq_from_id,
                                           bus.stallreq_from_ex, bus.stallreq_from_mem);
                end
            end
            ST_PEND: begin
                use_pend = 1'b1;
                if (bus.stallreq_from_mem) begin
                    stall_c = STALL_MEM;
                end else begin
                    flush_c   = 1'b1;
                    state_nxt = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                // Recovery cycle: everything, including excepttype, ignored.
                state_nxt = ST_RUN;
            end
            default: begin
                state_nxt = ST_RUN;
            end
        endcase
    end

    // Target operands: latched in PEND, live otherwise.
    always_comb begin
        tgt_code = use_pend ? pend_code : bus.excepttype;
        tgt_epc  = use_pend ? pend_epc  : bus.cp0_epc;
    end

    exc_target #(.EXC_VECTOR(EXC_VECTOR)) u_exc_target (
        .excepttype (tgt_code),
        .epc        (tgt_epc),
        .new_pc     (tgt_pc)
    );

    // Outputs are quiet while reset is held so pipeline registers see no
    // stray hold/flush; new_pc reads 0 outside a flush.
    assign bus.stall  = rst ? STALL_NONE : stall_c;
    assign bus.flush  = !rst && flush_c;
    assign bus.new_pc = (!rst && flush_c) ? tgt_pc : 32'h0;

`ifdef PIPE_CTRL_PERF_EN
    // Free-running wrap-around counters of pc-stall cycles and flushes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_stall_cycles <= '0;
            perf_flush_count  <= '0;
        end else begin
            if (bus.stall[0]) perf_stall_cycles <= perf_stall_cycles + 32'd1;
            if (bus.flush)    perf_flush_count  <= perf_flush_count + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: directed scenarios followed by random
// traffic, all compared against a behavioural model of the controller.
module tb_pipe_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;
    pipe_ctrl_if bus();

`ifdef PIPE_CTRL_PERF_EN
    logic [31:0] perf_stall_cycles, perf_flush_count;
`endif

    pipe_ctrl #(.EXC_VECTOR(32'h0000_0020)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
`ifdef PIPE_CTRL_PERF_EN
        ,
        .perf_stall_cycles (perf_stall_cycles),
        .perf_flush_count  (perf_flush_count)
`endif
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Model: one optionally parked exception, a recovery flag after each
    // flush, and event counts.
    logic        m_pend  = 1'b0;
    logic [31:0] m_code  = '0;
    logic [31:0] m_epc   = '0;
    logic        m_recov = 1'b0;
    logic [31:0] m_sc    = '0;
    logic [31:0] m_fc    = '0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: got %h, want %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] target(input logic [31:0] code, input logic [31:0] epc);
        return (code == 32'h0000_000e) ? epc : 32'h0000_0020;
    endfunction

    task automatic model_out(output logic [5:0] s, output logic f, output logic [31:0] pc);
        s = 6'b0; f = 1'b0; pc = 32'h0;
        if (rst || m_recov) begin
            // quiet
        end else if (m_pend) begin
            if (bus.stallreq_from_mem) s = 6'b011111;
            else begin f = 1'b1; pc = target(m_code, m_epc); end
        end else if (bus.excepttype != 0) begin
            if (bus.stallreq_from_mem) s = 6'b011111;
            else begin f = 1'b1; pc = target(bus.excepttype, bus.cp0_epc); end
        end else if (bus.stallreq_from_mem) s = 6'b011111;
        else if (bus.stallreq_from_ex)      s = 6'b001111;
        else if (bus.stallreq_from_id)      s = 6'b000111;
        else if (bus.stallreq_from_if)      s = 6'b000011;
    endtask

    task automatic model_reset();
        m_pend = 1'b0; m_code = '0; m_epc = '0; m_recov = 1'b0;
        m_sc = '0; m_fc = '0;
    endtask

    task automatic check_now(input string tag);
        logic [5:0] s; logic f; logic [31:0] pc;
        model_out(s, f, pc);
        chk({tag, ".stall"},  {26'h0, bus.stall}, {26'h0, s});
        chk({tag, ".flush"},  {31'h0, bus.flush}, {31'h0, f});
        chk({tag, ".new_pc"}, bus.new_pc, pc);
`ifdef PIPE_CTRL_PERF_EN
        chk({tag, ".perf_sc"}, perf_stall_cycles, m_sc);
        chk({tag, ".perf_fc"}, perf_flush_count, m_fc);
`endif
    endtask

    // Advance the model on the clock edge, then leave inputs settable.
    task automatic tick();
        logic [5:0] s; logic f; logic [31:0] pc;
        @(posedge clk);
        model_out(s, f, pc);
        if (rst) model_reset();
        else begin
            if (s[0]) m_sc++;
            if (f)    m_fc++;
            if (m_pend && !bus.stallreq_from_mem) m_pend = 1'b0;
            else if (!m_pend && !m_recov && bus.excepttype != 0 && bus.stallreq_from_mem) begin
                m_pend = 1'b1; m_code = bus.excepttype; m_epc = bus.cp0_epc;
            end
            m_recov = f;
        end
        #1;
    endtask

    task automatic cycle(input string tag);
        @(negedge clk);
        check_now(tag);
        tick();
    endtask

    // Model check plus explicit expected values for the directed scenarios.
    task automatic cyc_exp(input string tag, input logic [5:0] es, input logic ef, input logic [31:0] epc);
        @(negedge clk);
        check_now(tag);
        chk({tag, ".k_stall"},  {26'h0, bus.stall}, {26'h0, es});
        chk({tag, ".k_flush"},  {31'h0, bus.flush}, {31'h0, ef});
        chk({tag, ".k_new_pc"}, bus.new_pc, epc);
        tick();
    endtask

    task automatic set_in(input logic i_if, input logic i_id, input logic i_ex, input logic i_mem,
                          input logic [31:0] exc, input logic [31:0] epc);
        bus.stallreq_from_if  = i_if;
        bus.stallreq_from_id  = i_id;
        bus.stallreq_from_ex  = i_ex;
        bus.stallreq_from_mem = i_mem;
        bus.excepttype        = exc;
        bus.cp0_epc           = epc;
    endtask

    initial begin
        logic [31:0] codes [8];
        codes[0] = 32'h1; codes[1] = 32'h8; codes[2] = 32'ha; codes[3] = 32'hd;
        codes[4] = 32'hc; codes[5] = 32'he; codes[6] = 32'h5; codes[7] = 32'h1234;

        set_in(1'b1, 1'b1, 1'b1, 1'b1, 32'h0, 32'h0);
        #2;
        check_now("reset");
        chk("reset.k_stall", {26'h0, bus.stall}, 32'h0);
        tick();
        rst = 1'b0;
        set_in(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        cyc_exp("idle", 6'b000000, 1'b0, 32'h0);

        // ex busy for three cycles
        set_in(1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 32'h0);
        for (int i = 0; i < 3; i++) cyc_exp("ex_stall", 6'b001111, 1'b0, 32'h0);
        set_in(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        cyc_exp("ex_done", 6'b000000, 1'b0, 32'h0);

        set_in(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        cyc_exp("if_only", 6'b000011, 1'b0, 32'h0);
        set_in(1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
        cyc_exp("id_if", 6'b000111, 1'b0, 32'h0);
        set_in(1'b0, 1'b1, 1'b0, 1'b1, 32'h0, 32'h0);
        cyc_exp("id_mem", 6'b011111, 1'b0, 32'h0);

        // syscall, no mem stall: same-cycle flush, then recovery
        set_in(1'b0, 1'b1, 1'b1, 1'b0, 32'h8, 32'h1111_0000);
        cyc_exp("syscall", 6'b000000, 1'b1, 32'h0000_0020);
        set_in(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        cyc_exp("syscall_rec", 6'b000000, 1'b0, 32'h0);

        // eret returns to EPC
        set_in(1'b0, 1'b0, 1'b0, 1'b0, 32'he, 32'hBFC0_0100);
        cyc_exp("eret", 6'b000000, 1'b1, 32'hBFC0_0100);
        set_in(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        cyc_exp("eret_rec", 6'b000000, 1'b0, 32'h0);

        // overflow during a 4-cycle mem stall; inputs become garbage
        set_in(1'b0, 1'b0, 1'b0, 1'b1, 32'hc, 32'h0000_4444);
        cyc_exp("ov_pend0", 6'b011111, 1'b0, 32'h0);
        set_in(1'b1, 1'b1, 1'b1, 1'b1, 32'he, 32'hDEAD_BEEF);
        for (int i = 1; i < 4; i++) cyc_exp("ov_pend", 6'b011111, 1'b0, 32'h0);
        set_in(1'b0, 1'b0, 1'b0, 1'b0, 32'he, 32'hDEAD_BEEF);
        cyc_exp("ov_flush", 6'b000000, 1'b1, 32'h0000_0020);
        cyc_exp("ov_rec", 6'b000000, 1'b0, 32'h0);
        set_in(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        cyc_exp("ov_idle", 6'b000000, 1'b0, 32'h0);

        // reset while parked in PEND
        set_in(1'b0, 1'b0, 1'b0, 1'b1, 32'h8, 32'h0);
        cyc_exp("rst_pend0", 6'b011111, 1'b0, 32'h0);
        rst = 1'b1;
        model_reset();
        #1;
        check_now("rst_pend");
        chk("rst_pend.k_stall", {26'h0, bus.stall}, 32'h0);
        chk("rst_pend.k_flush", {31'h0, bus.flush}, 32'h0);
`ifdef PIPE_CTRL_PERF_EN
        chk("rst_pend.k_sc", perf_stall_cycles, 32'h0);
        chk("rst_pend.k_fc", perf_flush_count, 32'h0);
`endif
        tick();
        rst = 1'b0;
        set_in(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        cyc_exp("post_rst", 6'b000000, 1'b0, 32'h0);

        // random traffic
        for (int n = 0; n < 600; n++) begin
            bus.stallreq_from_if  = ($urandom_range(0, 9) < 3);
            bus.stallreq_from_id  = ($urandom_range(0, 9) < 2);
            bus.stallreq_from_ex  = ($urandom_range(0, 9) < 2);
            bus.stallreq_from_mem = ($urandom_range(0, 9) < 4);
            bus.excepttype        = ($urandom_range(0, 9) < 2) ? codes[$urandom_range(0, 7)] : 32'h0;
            bus.cp0_epc           = $urandom;
            cycle("rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
